// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-requester IO bus arbiter:
// FSM encoding, default idle address and requester index constants.
package io_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_PORT_DEFAULT = 8'hFF;

  localparam logic REQ_IDX0 = 1'b0;
  localparam logic REQ_IDX1 = 1'b1;

  // Requester index to one-hot grant vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return (idx == REQ_IDX1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared
// peripheral port. The arbiter uses the slave view; the requesters and
// peripheral side use the master view.
interface io_bus_arbiter_if;

  // requester side
  logic       req0;
  logic       req1;
  logic       we0;
  logic       we1;
  logic [7:0] port0;
  logic [7:0] port1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;

  // peripheral side
  logic [7:0] port_id;
  logic [7:0] data_out;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] data_in;

  // status
  logic [1:0] grant;
  logic       busy;

  modport slave (
    input  req0, req1, we0, we1, port0, port1, wdata0, wdata1, data_in,
    output ack0, ack1, rdata0, rdata1, port_id, data_out,
           write_strobe, read_strobe, grant, busy
  );

  modport master (
    output req0, req1, we0, we1, port0, port1, wdata0, wdata1, data_in,
    input  ack0, ack1, rdata0, rdata1, port_id, data_out,
           write_strobe, read_strobe, grant, busy
  );

endinterface

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Two-way grant selection, purely combinational. A lone request wins;
// on a tie the requester not granted last wins, unless fixed priority
// is enabled, in which case requester 0 wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] grant
);

  // Tie breaking: last==1 means requester 1 was served most recently.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (fixed || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates two requesters onto a single strobed peripheral port.
// Transfer sequence: IDLE -> STROBE -> (CAPTURE on reads) -> ACK -> IDLE.
// All outputs come straight from registers.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int         FIXED_PRIORITY = 0,
  parameter logic [7:0] IDLE_PORT      = IDLE_PORT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  io_bus_arbiter_if.slave    bus
);

  localparam logic FIXED_EN = (FIXED_PRIORITY != 0);

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       last_reg, last_next;
  logic       we_reg, we_next;
  logic [7:0] port_id_reg, port_id_next;
  logic [7:0] data_out_reg, data_out_next;
  logic       wstb_reg, wstb_next;
  logic       rstb_reg, rstb_next;
  logic       ack0_reg, ack0_next;
  logic       ack1_reg, ack1_next;
  logic [7:0] rdata0_reg, rdata0_next;
  logic [7:0] rdata1_reg, rdata1_next;
  logic [1:0] grant_reg, grant_next;
  logic       busy_reg, busy_next;
  logic [1:0] arb_grant;
  logic       win_idx;

  rr_arbiter2 u_rr_arbiter2 (
    .req   ({bus.req1, bus.req0}),
    .last  (last_reg),
    .fixed (FIXED_EN),
    .grant (arb_grant)
  );

  assign win_idx = arb_grant[1];

  // Next-state and next-output computation; strobes and acks default low
  // so each is a single-cycle pulse.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    we_next       = we_reg;
    port_id_next  = port_id_reg;
    data_out_next = data_out_reg;
    wstb_next     = 1'b0;
    rstb_next     = 1'b0;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    rdata0_next   = rdata0_reg;
    rdata1_next   = rdata1_reg;
    grant_next    = grant_reg;
    busy_next     = busy_reg;

    case (state_reg)
      ST_IDLE: begin
        if (arb_grant != 2'b00) begin
          owner_next    = win_idx;
          last_next     = win_idx;
          grant_next    = idx_to_onehot(win_idx);
          we_next       = (win_idx == REQ_IDX1) ? bus.we1    : bus.we0;
          port_id_next  = (win_idx == REQ_IDX1) ? bus.port1  : bus.port0;
          data_out_next = (win_idx == REQ_IDX1) ? bus.wdata1 : bus.wdata0;
          wstb_next     = (win_idx == REQ_IDX1) ? bus.we1    : bus.we0;
          rstb_next     = (win_idx == REQ_IDX1) ? ~bus.we1   : ~bus.we0;
          busy_next     = 1'b1;
          state_next    = ST_STROBE;
        end
      end

      ST_STROBE: begin
        if (we_reg) begin
          ack0_next  = (owner_reg == REQ_IDX0);
          ack1_next  = (owner_reg == REQ_IDX1);
          state_next = ST_ACK;
        end else begin
          state_next = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // Peripheral registered its read data on the previous edge.
        if (owner_reg == REQ_IDX1) begin
          rdata1_next = bus.data_in;
        end else begin
          rdata0_next = bus.data_in;
        end
        ack0_next  = (owner_reg == REQ_IDX0);
        ack1_next  = (owner_reg == REQ_IDX1);
        state_next = ST_ACK;
      end

      ST_ACK: begin
        grant_next   = 2'b00;
        port_id_next = IDLE_PORT;
        busy_next    = 1'b0;
        state_next   = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= REQ_IDX0;
      last_reg     <= REQ_IDX1;
      we_reg       <= 1'b0;
      port_id_reg  <= IDLE_PORT;
      data_out_reg <= 8'h00;
      wstb_reg     <= 1'b0;
      rstb_reg     <= 1'b0;
      ack0_reg     <= 1'b0;
      ack1_reg     <= 1'b0;
      rdata0_reg   <= 8'h00;
      rdata1_reg   <= 8'h00;
      grant_reg    <= 2'b00;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      we_reg       <= we_next;
      port_id_reg  <= port_id_next;
      data_out_reg <= data_out_next;
      wstb_reg     <= wstb_next;
      rstb_reg     <= rstb_next;
      ack0_reg     <= ack0_next;
      ack1_reg     <= ack1_next;
      rdata0_reg   <= rdata0_next;
      rdata1_reg   <= rdata1_next;
      grant_reg    <= grant_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.ack0         = ack0_reg;
  assign bus.ack1         = ack1_reg;
  assign bus.rdata0       = rdata0_reg;
  assign bus.rdata1       = rdata1_reg;
  assign bus.port_id      = port_id_reg;
  assign bus.data_out     = data_out_reg;
  assign bus.write_strobe = wstb_reg;
  assign bus.read_strobe  = rstb_reg;
  assign bus.grant        = grant_reg;
  assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter. Two instances (round-robin and
// fixed priority) share one set of stimulus signals; sel picks which one
// sees the requests and whose outputs are observed.
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sel;
  logic       req0, req1, we0, we1;
  logic [7:0] port0, port1, wdata0, wdata1;
  logic [7:0] data_in;

  io_bus_arbiter_if a_if();
  io_bus_arbiter_if b_if();

  assign a_if.req0 = req0 & ~sel;
  assign a_if.req1 = req1 & ~sel;
  assign b_if.req0 = req0 & sel;
  assign b_if.req1 = req1 & sel;
  assign a_if.we0 = we0;       assign b_if.we0 = we0;
  assign a_if.we1 = we1;       assign b_if.we1 = we1;
  assign a_if.port0 = port0;   assign b_if.port0 = port0;
  assign a_if.port1 = port1;   assign b_if.port1 = port1;
  assign a_if.wdata0 = wdata0; assign b_if.wdata0 = wdata0;
  assign a_if.wdata1 = wdata1; assign b_if.wdata1 = wdata1;
  assign a_if.data_in = data_in;
  assign b_if.data_in = data_in;

  io_bus_arbiter #(.FIXED_PRIORITY(0), .IDLE_PORT(8'hFF)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  io_bus_arbiter #(.FIXED_PRIORITY(1), .IDLE_PORT(8'hFF)) dut_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // Observed outputs of the selected instance.
  logic       ack0, ack1, ws, rs, busy;
  logic [7:0] rdata0, rdata1, port_id, data_out;
  logic [1:0] grant;
  assign ack0     = sel ? b_if.ack0         : a_if.ack0;
  assign ack1     = sel ? b_if.ack1         : a_if.ack1;
  assign ws       = sel ? b_if.write_strobe : a_if.write_strobe;
  assign rs       = sel ? b_if.read_strobe  : a_if.read_strobe;
  assign busy     = sel ? b_if.busy         : a_if.busy;
  assign rdata0   = sel ? b_if.rdata0       : a_if.rdata0;
  assign rdata1   = sel ? b_if.rdata1       : a_if.rdata1;
  assign port_id  = sel ? b_if.port_id      : a_if.port_id;
  assign data_out = sel ? b_if.data_out     : a_if.data_out;
  assign grant    = sel ? b_if.grant        : a_if.grant;

  // Peripheral model: registered read data, valid the cycle after read_strobe.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rs) data_in <= mem[port_id];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  int         last_model;
  logic [7:0] rdata_model [2];

  // Protocol monitor: exclusive strobes, one-cycle strobes, one ack per grant.
  logic ws_prev, rs_prev;
  int   ack_cnt;
  always @(negedge clk) begin
    if (reset) begin
      ws_prev <= 1'b0;
      rs_prev <= 1'b0;
      ack_cnt <= 0;
    end else begin
      checks++;
      if (ws && rs) begin
        errors++;
        $display("FAIL mon_strobe_excl ws=%0b rs=%0b required not both high", ws, rs);
      end
      checks++;
      if ((ws && ws_prev) || (rs && rs_prev)) begin
        errors++;
        $display("FAIL mon_strobe_width ws=%0b/%0b rs=%0b/%0b required 1-cycle", ws_prev, ws, rs_prev, rs);
      end
      if (grant == 2'b00) begin
        ack_cnt <= 0;
      end else if (ack0 || ack1) begin
        checks++;
        if (ack_cnt >= 1 || (ack0 && ack1)) begin
          errors++;
          $display("FAIL mon_ack_per_grant count=%0d required 0 before this ack", ack_cnt);
        end
        ack_cnt <= ack_cnt + 1;
      end
      ws_prev <= ws;
      rs_prev <= rs;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_model = 1;
    rdata_model[0] = 8'h00;
    rdata_model[1] = 8'h00;
  endtask

  // One transfer from IDLE to the IDLE cycle after ACK, checked against
  // the arbitration and latency rules.
  task automatic run_xfer(input logic r0, input logic r1, input logic w0, input logic w1,
                          input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input bit hold, input string tag);
    int         win;
    int         cyc;
    int         lat;
    bit         seen;
    logic       ew;
    logic [7:0] ep, ed;
    logic [1:0] eg;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    port0 = p0; port1 = p1; wdata0 = d0; wdata1 = d1;
    if (r0 && r1) win = sel ? 0 : (last_model == 0 ? 1 : 0);
    else          win = r0 ? 0 : 1;
    ew = (win == 1) ? w1 : w0;
    ep = (win == 1) ? p1 : p0;
    ed = (win == 1) ? d1 : d0;
    eg = (win == 1) ? 2'b10 : 2'b01;

    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant !== eg) begin
      errors++;
      $display("FAIL %s_grant busy=%0b grant=%b required busy=1 grant=%b", tag, busy, grant, eg);
    end
    checks++;
    if (port_id !== ep) begin
      errors++;
      $display("FAIL %s_port_id got=%02h required=%02h", tag, port_id, ep);
    end
    checks++;
    if (ws !== ew || rs !== ~ew) begin
      errors++;
      $display("FAIL %s_strobe ws=%0b rs=%0b required ws=%0b rs=%0b", tag, ws, rs, ew, ~ew);
    end
    if (ew) begin
      checks++;
      if (data_out !== ed) begin
        errors++;
        $display("FAIL %s_data_out got=%02h required=%02h", tag, data_out, ed);
      end
    end

    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 6) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) seen = 1'b1;
    end
    lat = ew ? 2 : 3;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_ack_timeout no ack within %0d cycles required ack at %0d", tag, cyc, lat);
    end else begin
      checks++;
      if (cyc != lat) begin
        errors++;
        $display("FAIL %s_latency got=%0d required=%0d", tag, cyc, lat);
      end
      checks++;
      if ({ack1, ack0} !== eg) begin
        errors++;
        $display("FAIL %s_ack_owner got=%b required=%b", tag, {ack1, ack0}, eg);
      end
      if (!ew) rdata_model[win] = mem[ep];
      checks++;
      if (rdata0 !== rdata_model[0] || rdata1 !== rdata_model[1]) begin
        errors++;
        $display("FAIL %s_rdata got=%02h/%02h required=%02h/%02h", tag, rdata0, rdata1,
                 rdata_model[0], rdata_model[1]);
      end
    end
    last_model = win;
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end

    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00 || port_id !== 8'hFF || ws !== 1'b0 ||
        rs !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy=%0b grant=%b port_id=%02h ws=%0b rs=%0b ack=%b required 0/00/FF/0/0/00",
               tag, busy, grant, port_id, ws, rs, {ack1, ack0});
    end
    $display("XFER %s win=%0d we=%0b port=%02h data=%02h lat=%0d rdata=%02h/%02h",
             tag, win, ew, ep, ew ? ed : mem[ep], cyc, rdata0, rdata1);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00 || port_id !== 8'hFF || data_out !== 8'h00 ||
        ws !== 1'b0 || rs !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 ||
        rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_state busy=%0b grant=%b port_id=%02h data_out=%02h rdata=%02h/%02h required all idle",
               busy, grant, port_id, data_out, rdata0, rdata1);
    end
    $display("XFER reset busy=%0b port_id=%02h", busy, port_id);
  endtask

  task automatic test_write();
    run_xfer(1, 0, 1, 0, 8'h01, 8'h00, 8'h5A, 8'h00, 0, "write0");
  endtask

  task automatic test_read();
    mem[8'h02] = 8'hC3;
    run_xfer(0, 1, 0, 0, 8'h00, 8'h02, 8'h00, 8'h00, 0, "read1");
  endtask

  task automatic test_round_robin();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_xfer(1, 1, 1, 0, 8'h10, 8'h11, 8'hA5, 8'h00, i < 3, "rr_held");
    end
  endtask

  task automatic test_fixed_priority();
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_xfer(1, 1, i[0], 1, 8'h20, 8'h21, 8'h3C, 8'h4B, i < 3, "fixed_held");
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] r;
    sel = 1'b0;
    for (int i = 0; i < 30; i++) begin
      r = 2'($urandom_range(1, 3));
      run_xfer(r[0], r[1], 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 0, "random");
    end
  endtask

  task automatic test_reset_mid_read();
    sel = 1'b0;
    do_reset();
    req1 = 1'b1; we1 = 1'b0; port1 = 8'h07;
    @(negedge clk);
    checks++;
    if (rs !== 1'b1) begin
      errors++;
      $display("FAIL midrst_strobe rs=%0b required 1", rs);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_capture busy=%0b ack1=%0b required 1/0", busy, ack1);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || port_id !== 8'hFF ||
        ws !== 1'b0 || rs !== 1'b0 || grant !== 2'b00 || rdata1 !== 8'h00) begin
      errors++;
      $display("FAIL midrst_after busy=%0b ack=%b port_id=%02h ws=%0b rs=%0b grant=%b rdata1=%02h required idle",
               busy, {ack1, ack0}, port_id, ws, rs, grant, rdata1);
    end
    reset = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ack0 || ack1 || ws || rs || busy) begin
        errors++;
        $display("FAIL midrst_quiet cycle=%0d ack=%b ws=%0b rs=%0b busy=%0b required all 0",
                 i, {ack1, ack0}, ws, rs, busy);
      end
    end
    rdata_model[0] = 8'h00;
    rdata_model[1] = 8'h00;
    last_model = 1;
    $display("XFER reset_mid_read port_id=%02h busy=%0b", port_id, busy);
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    port0 = 8'h00; port1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    data_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_random();
    test_fixed_priority();
    test_reset_mid_read();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin, 1 = requester 0 always wins ties.
REQ-002 Parameter IDLE_PORT, default 8'hFF, meaning the port_id value driven while no transfer is active.
REQ-003 Port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 Ports req0/req1, input, 1 each, meaning the requester holds a transfer request.
REQ-006 Ports we0/we1, input, 1 each, meaning 1 = write, 0 = read; held stable while req is high.
REQ-007 Ports port0/port1, input, 8 each, meaning target port address; held stable while req is high.
REQ-008 Ports wdata0/wdata1, input, 8 each, meaning write data; held stable while req is high.
REQ-009 Ports ack0/ack1, output, 1 each, meaning a one-cycle completion pulse.
REQ-010 Ports rdata0/rdata1, output, 8 each, meaning read data, valid in the ack cycle and held until that requester's next ack.
REQ-011 Port port_id, output, 8, meaning the shared peripheral address.
REQ-012 Port data_out, output, 8, meaning write data to the peripherals.
REQ-013 Ports write_strobe/read_strobe, output, 1 each, meaning single-cycle strobes to the peripherals.
REQ-014 Port data_in, input, 8, meaning peripheral read data; registered by the peripheral, valid the cycle after read_strobe.
REQ-015 Ports grant, output, 2, meaning one-hot owner of the current transfer, and busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, STROBE, CAPTURE, ACK; every output is registered.
REQ-017 In IDLE, the arbiter SHALL sample req0/req1 and, if either is high, latch the winner's we, port and wdata, set grant, and go to STROBE.
REQ-018 Arbitration SHALL follow these rules: if only one req is high, that requester wins; if both are high in round-robin mode, the requester not granted last wins; if both are high with FIXED_PRIORITY=1, requester 0 wins.
REQ-019 In STROBE, the arbiter SHALL drive port_id and data_out from the latched values and assert exactly one strobe for exactly one cycle.
REQ-020 On a write, STROBE SHALL be followed by ACK; on a read, STROBE SHALL be followed by CAPTURE, where data_in is registered into the owner's rdata, and then by ACK.
REQ-021 In ACK, the owner's ack SHALL pulse for one cycle; the FSM then returns to IDLE, grant clears, and port_id returns to IDLE_PORT.
REQ-022 Latency from req high in IDLE to ack SHALL be 2 cycles for a write and 3 cycles for a read.
REQ-023 Back-to-back transfers SHALL be separated by at least one IDLE cycle; in ACK a requester SHALL lower req or present its next transfer.
REQ-024 Req changes outside IDLE SHALL be ignored; a req withdrawn before grant is dropped silently.
REQ-025 port_id SHALL hold its latched value through STROBE and CAPTURE.
REQ-026 Unmapped ports SHALL need no special handling; rdata takes whatever data_in returns.

Reset
REQ-027 Reset SHALL force IDLE, port_id=IDLE_PORT, data_out=0, both strobes=0, both acks=0, grant=0, busy=0, rdata0=rdata1=0, and last-granted=requester 1, so requester 0 wins the first tie.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no ack and no further strobe.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the IDLE_PORT default and the requester-index constants.
REQ-030 Grant selection SHALL live in one sub-module, rr_arbiter2 (inputs req[1:0], last, fixed; output one-hot grant), combinational only.

Verification
REQ-031 req0 write, port 8'h01, wdata 8'h5A -> write_strobe one cycle later with port_id=01, data_out=5A; ack0 two cycles after req.
REQ-032 req1 read, port 8'h02, peripheral returns 8'hC3 the cycle after read_strobe -> ack1 three cycles after req, rdata1=C3, rdata0 unchanged.
REQ-033 req0 and req1 held continuously in round-robin mode -> grants alternate 0,1,0,1 starting with 0, one IDLE cycle between transfers.
REQ-034 Same as REQ-033 with FIXED_PRIORITY=1 -> requester 0 is always granted and requester 1 never gets ack.
REQ-035 reset asserted in the CAPTURE cycle of a read -> next cycle IDLE, no ack, port_id=FF, strobes low.
REQ-036 Checker on every test: never both strobes high, strobe width exactly 1 cycle, at most one ack per grant.
